// File: rtl/arm_multicycle_controller.sv
// Moore-style multicycle ARM control unit: decodes Instr[31:12], sequences the shared-memory
// datapath, holds NZCV and gates architectural writes on the condition field.
module arm_multicycle_controller #(
  parameter int MEM_LATENCY = 0,
  parameter int ALUCTRL_W   = 3,
  parameter int BYTE_EN     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 OnlyByte,
  output logic                 Illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_ORR = 3'd3, ALU_EOR = 3'd4;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t     state, nxt;
  logic [3:0] cnt;
  logic [3:0] flags;

  // Instr holds bits 31:12, so instruction bit k sits at Instr[k-12]
  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit, u_bit, b_bit, l_bit;
  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign i_bit = Instr[13];
  assign cmd   = Instr[12:9];
  assign s_bit = Instr[8];
  assign u_bit = Instr[11];
  assign b_bit = Instr[10];
  assign l_bit = Instr[8];
  assign rd    = Instr[3:0];

  logic unused_rn;
  assign unused_rn = ^Instr[7:4];

  logic wait_done, byte_acc;
  assign wait_done = (cnt == 4'd0);
  assign byte_acc  = b_bit & (BYTE_EN != 0);

  logic cond_ex;
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      4'h0:    cond_ex = z;
      4'h1:    cond_ex = ~z;
      4'h2:    cond_ex = c;
      4'h3:    cond_ex = ~c;
      4'h4:    cond_ex = n;
      4'h5:    cond_ex = ~n;
      4'h6:    cond_ex = v;
      4'h7:    cond_ex = ~v;
      4'h8:    cond_ex = c & ~z;
      4'h9:    cond_ex = ~c | z;
      4'hA:    cond_ex = (n == v);
      4'hB:    cond_ex = (n != v);
      4'hC:    cond_ex = ~z & (n == v);
      4'hD:    cond_ex = z | (n != v);
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Undefined commands run as ADD but never write a register or the flags
  logic [2:0] alu_dp;
  logic       dp_valid, dp_write, dp_cv;
  always_comb begin
    alu_dp   = ALU_ADD;
    dp_valid = 1'b1;
    dp_write = 1'b1;
    dp_cv    = 1'b0;
    case (cmd)
      4'b0100: dp_cv = 1'b1;
      4'b0010: begin alu_dp = ALU_SUB; dp_cv = 1'b1; end
      4'b0000: alu_dp = ALU_AND;
      4'b1100: alu_dp = ALU_ORR;
      4'b0001: alu_dp = ALU_EOR;
      4'b1010: begin alu_dp = ALU_SUB; dp_cv = 1'b1; dp_write = 1'b0; end
      default: begin dp_valid = 1'b0; dp_write = 1'b0; end
    endcase
  end

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:    nxt = wait_done ? DECODE : FETCH;
      DECODE:
        case (op)
          2'b00:   nxt = i_bit ? EXECI : EXECR;
          2'b01:   nxt = MEMADR;
          2'b10:   nxt = BRANCH;
          default: nxt = FETCH;
        endcase
      EXECR,
      EXECI:    nxt = ALUWB;
      MEMADR:   nxt = l_bit ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = wait_done ? MEMWB : MEMREAD;
      MEMWRITE: nxt = wait_done ? FETCH : MEMWRITE;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= 4'b0000;
      cnt   <= 4'd0;
    end else begin
      state <= nxt;
      // wait states never self-loop except while counting, so nxt != state marks an entry
      if (nxt != state && (nxt == FETCH || nxt == MEMREAD || nxt == MEMWRITE))
        cnt <= LAT;
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if ((state == EXECR || state == EXECI) && s_bit && cond_ex && dp_valid) begin
        flags[3:2] <= ALUFlags[3:2];
        if (dp_cv) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  logic       pc_we, ir_we, mem_we, reg_we;
  logic [2:0] alu_sel;
  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ImmSrc    = 2'b00;
    RegSrc    = 2'b00;
    alu_sel   = ALU_ADD;
    OnlyByte  = 1'b0;
    Illegal   = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = wait_done;
        pc_we     = wait_done;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Illegal = (op == 2'b11);
      end
      EXECR: alu_sel = alu_dp;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_sel = alu_dp;
      end
      ALUWB: begin
        if (dp_write) begin
          if (rd == 4'hF) pc_we  = cond_ex;
          else            reg_we = cond_ex;
        end
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        alu_sel = u_bit ? ALU_ADD : ALU_SUB;
      end
      MEMREAD: begin
        AdrSrc   = 1'b1;
        OnlyByte = byte_acc;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_we    = cond_ex;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        RegSrc   = 2'b10;
        OnlyByte = byte_acc;
        mem_we   = cond_ex & wait_done;
      end
      BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        pc_we     = cond_ex;
      end
      default: ;
    endcase
  end

  assign ALUControl = ALUCTRL_W'(alu_sel);
  assign PCWrite    = pc_we  & ~reset;
  assign IRWrite    = ir_we  & ~reset;
  assign MemWrite   = mem_we & ~reset;
  assign RegWrite   = reg_we & ~reset;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Scoreboard bench: directed instruction streams push per-cycle expected control words,
// a negedge monitor pops and compares them against two controller instances (latency 0 and 2).
module tb_arm_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {T_F, T_D, T_ER, T_EI, T_WB, T_MA, T_MR, T_MWB, T_MW, T_BR} tst_t;
  typedef struct {
    logic [18:0] val;
    logic [18:0] care;
    string       name;
  } exp_t;

  // control word bit positions
  localparam int PCW = 18, ADR = 17, MW = 16, IRW = 15, RES = 13, SRCA = 12, SRCB = 10,
                 IMM = 8, REGS = 6, RW = 5, ALU = 2, OB = 1, ILL = 0;
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_ORR = 3'd3, A_EOR = 3'd4;
  // write enables given as {PCWrite, MemWrite, IRWrite, RegWrite}
  localparam logic [3:0] W_NONE = 4'b0000, W_PC = 4'b1000, W_MEM = 4'b0100,
                         W_FET = 4'b1010, W_REG = 4'b0001;

  localparam logic [19:0] I_ADD   = 20'hE0821, I_BEQ  = 20'h0A000, I_BNE  = 20'h1A000,
                          I_SUBS  = 20'hE2500, I_STRNE = 20'h15821, I_STR = 20'hE5821,
                          I_LDRM  = 20'hE5154, I_ORR  = 20'hE1821, I_EOR  = 20'hE0221,
                          I_CMP   = 20'hE1510, I_BGE  = 20'hAA000, I_BLT  = 20'hBA000,
                          I_ANDS  = 20'hE0121, I_BVS  = 20'h6A000, I_BCS  = 20'h2A000,
                          I_UNDEF = 20'hE0712, I_BMI  = 20'h4A000, I_ADDPC = 20'hE081F,
                          I_ILL   = 20'hEC000, I_B    = 20'hEA000, I_LDRB = 20'hE5D54,
                          I_STRB  = 20'hE5C21;

  logic        rst0, rst2;
  logic [19:0] ins0, ins2;
  logic [3:0]  fl0, fl2;
  logic [18:0] ctl0, ctl2;

  logic pcw0, adr0, mw0, irw0, srca0, rw0, ob0, ill0;
  logic [1:0] res0, srcb0, imm0, regs0;
  logic [2:0] alu0;
  logic pcw2, adr2, mw2, irw2, srca2, rw2, ob2, ill2;
  logic [1:0] res2, srcb2, imm2, regs2;
  logic [2:0] alu2;

  arm_multicycle_controller #(.MEM_LATENCY(0), .ALUCTRL_W(3), .BYTE_EN(1)) u0 (
    .clk(clk), .reset(rst0), .Instr(ins0), .ALUFlags(fl0),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(res0),
    .ALUSrcA(srca0), .ALUSrcB(srcb0), .ImmSrc(imm0), .RegSrc(regs0), .RegWrite(rw0),
    .ALUControl(alu0), .OnlyByte(ob0), .Illegal(ill0));

  arm_multicycle_controller #(.MEM_LATENCY(2), .ALUCTRL_W(3), .BYTE_EN(1)) u2 (
    .clk(clk), .reset(rst2), .Instr(ins2), .ALUFlags(fl2),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .ResultSrc(res2),
    .ALUSrcA(srca2), .ALUSrcB(srcb2), .ImmSrc(imm2), .RegSrc(regs2), .RegWrite(rw2),
    .ALUControl(alu2), .OnlyByte(ob2), .Illegal(ill2));

  assign ctl0 = {pcw0, adr0, mw0, irw0, res0, srca0, srcb0, imm0, regs0, rw0, alu0, ob0, ill0};
  assign ctl2 = {pcw2, adr2, mw2, irw2, res2, srca2, srcb2, imm2, regs2, rw2, alu2, ob2, ill2};

  exp_t q0[$], q2[$];
  int ncmp = 0, nerr = 0;

  function automatic exp_t put(input exp_t e, input int hi, input int lo, input logic [2:0] v);
    for (int b = lo; b <= hi; b++) begin
      e.val[b]  = v[b-lo];
      e.care[b] = 1'b1;
    end
    return e;
  endfunction

  // Expected word for one cycle of a state; only fields the state defines are cared about.
  function automatic exp_t mk(input tst_t s, input logic [3:0] w, input logic [2:0] alu,
                              input logic ob, input logic ill, input string nm);
    exp_t e;
    e.val = '0; e.care = '0; e.name = nm;
    e = put(e, PCW, PCW, {2'b0, w[3]});
    e = put(e, MW, MW, {2'b0, w[2]});
    e = put(e, IRW, IRW, {2'b0, w[1]});
    e = put(e, RW, RW, {2'b0, w[0]});
    e = put(e, OB, OB, {2'b0, ob});
    e = put(e, ILL, ILL, {2'b0, ill});
    case (s)
      T_F: begin
        e = put(e, ADR, ADR, 3'd0);   e = put(e, SRCA, SRCA, 3'd1);
        e = put(e, SRCB+1, SRCB, 3'd2); e = put(e, ALU+2, ALU, A_ADD);
        e = put(e, RES+1, RES, 3'd2);
      end
      T_D: begin
        e = put(e, SRCA, SRCA, 3'd1); e = put(e, SRCB+1, SRCB, 3'd2);
        e = put(e, ALU+2, ALU, A_ADD);
      end
      T_ER: begin
        e = put(e, SRCB+1, SRCB, 3'd0); e = put(e, ALU+2, ALU, alu);
      end
      T_EI: begin
        e = put(e, SRCB+1, SRCB, 3'd1); e = put(e, IMM+1, IMM, 3'd0);
        e = put(e, ALU+2, ALU, alu);
      end
      T_WB:  e = put(e, RES+1, RES, 3'd0);
      T_MA: begin
        e = put(e, SRCA, SRCA, 3'd0); e = put(e, SRCB+1, SRCB, 3'd1);
        e = put(e, IMM+1, IMM, 3'd1); e = put(e, ALU+2, ALU, alu);
      end
      T_MR:  e = put(e, ADR, ADR, 3'd1);
      T_MWB: e = put(e, RES+1, RES, 3'd1);
      T_MW: begin
        e = put(e, ADR, ADR, 3'd1); e = put(e, REGS+1, REGS+1, 3'd1);
      end
      default: begin
        e = put(e, REGS, REGS, 3'd1); e = put(e, SRCA, SRCA, 3'd0);
        e = put(e, SRCB+1, SRCB, 3'd1); e = put(e, IMM+1, IMM, 3'd2);
        e = put(e, ALU+2, ALU, A_ADD); e = put(e, RES+1, RES, 3'd2);
      end
    endcase
    return e;
  endfunction

  task automatic cy(input int u, input logic rst, input logic [19:0] ins, input logic [3:0] fl,
                    input exp_t e);
    if (u == 0) begin rst0 = rst; ins0 = ins; fl0 = fl; q0.push_back(e); end
    else        begin rst2 = rst; ins2 = ins; fl2 = fl; q2.push_back(e); end
    @(posedge clk); #1;
  endtask

  // n FETCH cycles (write strobes on the last) followed by DECODE
  task automatic fd(input int u, input logic [19:0] ins, input int n, input logic ill,
                    input string nm);
    for (int k = 0; k < n; k++)
      cy(u, 1'b0, ins, 4'h0, mk(T_F, (k == n-1) ? W_FET : W_NONE, A_ADD, 1'b0, 1'b0, {nm, ".f"}));
    cy(u, 1'b0, ins, 4'h0, mk(T_D, W_NONE, A_ADD, 1'b0, ill, {nm, ".d"}));
  endtask

  task automatic br(input int u, input logic [19:0] ins, input int n, input logic taken,
                    input string nm);
    fd(u, ins, n, 1'b0, nm);
    cy(u, 1'b0, ins, 4'h0, mk(T_BR, taken ? W_PC : W_NONE, A_ADD, 1'b0, 1'b0, {nm, ".br"}));
  endtask

  task automatic dp(input int u, input logic [19:0] ins, input int n, input logic imm,
                    input logic [3:0] fl, input logic [2:0] alu, input logic [3:0] w,
                    input string nm);
    fd(u, ins, n, 1'b0, nm);
    cy(u, 1'b0, ins, fl, mk(imm ? T_EI : T_ER, W_NONE, alu, 1'b0, 1'b0, {nm, ".ex"}));
    cy(u, 1'b0, ins, 4'h0, mk(T_WB, w, A_ADD, 1'b0, 1'b0, {nm, ".wb"}));
  endtask

  task automatic chk(input logic [18:0] got, input exp_t e);
    ncmp++;
    if ((got & e.care) !== (e.val & e.care)) begin
      nerr++;
      $display("FAIL %s got=%h want=%h care=%h", e.name, got, e.val, e.care);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin e = q0.pop_front(); chk(ctl0, e); end
    if (q2.size() > 0) begin e = q2.pop_front(); chk(ctl2, e); end
  end

  initial begin
    rst0 = 1'b1; rst2 = 1'b1; ins0 = '0; ins2 = '0; fl0 = '0; fl2 = '0;
    @(posedge clk); #1;

    // ---- MEM_LATENCY = 0 ----
    cy(0, 1'b1, I_ADD, 4'h0, mk(T_F, W_NONE, A_ADD, 1'b0, 1'b0, "u0.rst0"));
    cy(0, 1'b1, I_ADD, 4'h0, mk(T_F, W_NONE, A_ADD, 1'b0, 1'b0, "u0.rst1"));
    dp(0, I_ADD, 1, 1'b0, 4'hF, A_ADD, W_REG, "add");
    br(0, I_BEQ, 1, 1'b0, "beq.flags0");
    dp(0, I_SUBS, 1, 1'b1, 4'b0110, A_SUB, W_REG, "subs");
    br(0, I_BEQ, 1, 1'b1, "beq.z1");
    br(0, I_BNE, 1, 1'b0, "bne.z1");
    fd(0, I_STRNE, 1, 1'b0, "strne");
    cy(0, 1'b0, I_STRNE, 4'h0, mk(T_MA, W_NONE, A_ADD, 1'b0, 1'b0, "strne.ma"));
    cy(0, 1'b0, I_STRNE, 4'h0, mk(T_MW, W_NONE, A_ADD, 1'b0, 1'b0, "strne.mw"));
    fd(0, I_STR, 1, 1'b0, "str");
    cy(0, 1'b0, I_STR, 4'h0, mk(T_MA, W_NONE, A_ADD, 1'b0, 1'b0, "str.ma"));
    cy(0, 1'b0, I_STR, 4'h0, mk(T_MW, W_MEM, A_ADD, 1'b0, 1'b0, "str.mw"));
    fd(0, I_LDRM, 1, 1'b0, "ldr");
    cy(0, 1'b0, I_LDRM, 4'h0, mk(T_MA, W_NONE, A_SUB, 1'b0, 1'b0, "ldr.ma"));
    cy(0, 1'b0, I_LDRM, 4'h0, mk(T_MR, W_NONE, A_ADD, 1'b0, 1'b0, "ldr.mr"));
    cy(0, 1'b0, I_LDRM, 4'h0, mk(T_MWB, W_REG, A_ADD, 1'b0, 1'b0, "ldr.mwb"));
    dp(0, I_ORR, 1, 1'b0, 4'h0, A_ORR, W_REG, "orr");
    dp(0, I_EOR, 1, 1'b0, 4'h0, A_EOR, W_REG, "eor");
    dp(0, I_CMP, 1, 1'b0, 4'b1001, A_SUB, W_NONE, "cmp");
    br(0, I_BGE, 1, 1'b1, "bge");
    br(0, I_BLT, 1, 1'b0, "blt");
    dp(0, I_ANDS, 1, 1'b0, 4'b0111, A_AND, W_REG, "ands");
    br(0, I_BVS, 1, 1'b1, "bvs.kept");
    br(0, I_BCS, 1, 1'b0, "bcs.kept");
    dp(0, I_UNDEF, 1, 1'b0, 4'b1000, A_ADD, W_NONE, "undef");
    br(0, I_BMI, 1, 1'b0, "bmi.noupd");
    dp(0, I_ADDPC, 1, 1'b0, 4'h0, A_ADD, W_PC, "addpc");
    fd(0, I_ILL, 1, 1'b1, "ill");
    br(0, I_B, 1, 1'b1, "b.after.ill");
    rst0 = 1'b1;

    // ---- MEM_LATENCY = 2 ----
    cy(2, 1'b1, I_ADD, 4'h0, mk(T_F, W_NONE, A_ADD, 1'b0, 1'b0, "u2.rst0"));
    cy(2, 1'b1, I_ADD, 4'h0, mk(T_F, W_NONE, A_ADD, 1'b0, 1'b0, "u2.rst1"));
    dp(2, I_ADD, 1, 1'b0, 4'h0, A_ADD, W_REG, "l2.add");
    fd(2, I_LDRB, 3, 1'b0, "ldrb");
    cy(2, 1'b0, I_LDRB, 4'h0, mk(T_MA, W_NONE, A_ADD, 1'b0, 1'b0, "ldrb.ma"));
    for (int k = 0; k < 3; k++)
      cy(2, 1'b0, I_LDRB, 4'h0, mk(T_MR, W_NONE, A_ADD, 1'b1, 1'b0, "ldrb.mr"));
    cy(2, 1'b0, I_LDRB, 4'h0, mk(T_MWB, W_REG, A_ADD, 1'b0, 1'b0, "ldrb.mwb"));
    fd(2, I_STRB, 3, 1'b0, "strb");
    cy(2, 1'b0, I_STRB, 4'h0, mk(T_MA, W_NONE, A_ADD, 1'b0, 1'b0, "strb.ma"));
    for (int k = 0; k < 3; k++)
      cy(2, 1'b0, I_STRB, 4'h0, mk(T_MW, (k == 2) ? W_MEM : W_NONE, A_ADD, 1'b1, 1'b0, "strb.mw"));
    dp(2, I_SUBS, 3, 1'b1, 4'b0110, A_SUB, W_REG, "l2.subs");
    fd(2, I_STR, 3, 1'b0, "l2.str");
    cy(2, 1'b0, I_STR, 4'h0, mk(T_MA, W_NONE, A_ADD, 1'b0, 1'b0, "l2.str.ma"));
    cy(2, 1'b0, I_STR, 4'h0, mk(T_MW, W_NONE, A_ADD, 1'b0, 1'b0, "l2.str.mw0"));
    cy(2, 1'b0, I_STR, 4'h0, mk(T_MW, W_NONE, A_ADD, 1'b0, 1'b0, "l2.str.mw1"));
    cy(2, 1'b1, I_STR, 4'h0, mk(T_MW, W_NONE, A_ADD, 1'b0, 1'b0, "l2.str.rst"));
    br(2, I_BEQ, 1, 1'b0, "l2.beq.flags0");
    br(2, I_BNE, 3, 1'b1, "l2.bne");
    rst2 = 1'b1;

    repeat (2) @(posedge clk);
    ncmp++;
    if (q0.size() != 0 || q2.size() != 0) begin
      nerr++;
      $display("FAIL drain q0=%0d q2=%0d want 0", q0.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
